vpu_addsub_seq: RTL and testbench

Sequencer that streams one vector add/sub command through a single shared 32-bit ripple adder, one element per cycle. Operands and results are 33-bit sign-magnitude: bit 32 is the sign and bits 31:0 are the magnitude. Each operand is converted to two's complement, added, and the result is converted back to sign-magnitude. The block sits between the VPU issue logic (command plus operand stream) and the VPU writeback (result stream), with valid/ready handshakes on all three interfaces.

---
 rtl/vpu_pkg.sv | 20 ++
 rtl/vpu_ripple_add32.sv | 27 ++
 rtl/vpu_sm_to_tc.sv | 20 ++
 rtl/vpu_addsub_seq.sv | 142 ++++++++++++++
 tb/tb_vpu_addsub_seq.sv | 371 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vpu_pkg
// Description : Shared types and constants for the VPU add/sub sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package vpu_pkg;

    typedef logic [32:0] sm33_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    localparam logic [31:0] SAT_MAG = 32'h7FFF_FFFF;

endpackage
`default_nettype wire

// File: rtl/vpu_ripple_add32.sv
`default_nettype none
// ============================================================================
// Module      : vpu_ripple_add32
// Description : 32-bit ripple-carry adder.
// Revision    : 1.0 - initial release
// ============================================================================
module vpu_ripple_add32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);

    logic [32:0] w_c;

    assign w_c[0] = cin;

    for (genvar i = 0; i < 32; i++) begin : g_bit
        assign sum[i]   = a[i] ^ b[i] ^ w_c[i];
        assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
    end

    assign cout = w_c[32];

endmodule
`default_nettype wire

// File: rtl/vpu_sm_to_tc.sv
`default_nettype none
// ============================================================================
// Module      : vpu_sm_to_tc
// Description : Sign-magnitude to 32-bit two's-complement conversion with an
//               unrepresentable-magnitude flag.
// Revision    : 1.0 - initial release
// ============================================================================
module vpu_sm_to_tc (
    input  logic        sign,
    input  logic [31:0] mag,
    output logic [31:0] tc,
    output logic        ovf
);

    assign tc  = sign ? (~mag + 32'd1) : mag;
    // A -0 input converts to 0 and is not flagged.
    assign ovf = (tc[31] != sign) && (mag != 32'd0);

endmodule
`default_nettype wire

// File: rtl/vpu_addsub_seq.sv
`default_nettype none
// ============================================================================
// Module      : vpu_addsub_seq
// Description : Streams one vector add/sub command through a shared ripple
//               adder, one sign-magnitude element per cycle.
//               Optional saturation on overflow: define VPU_ADDSUB_SAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module vpu_addsub_seq
    import vpu_pkg::*;
#(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_sub,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [32:0]      op_a,
    input  logic [32:0]      op_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [32:0]      res_data,
    output logic             res_ovf,
    output logic             done,
    output logic             ovf_sticky
);

    seq_state_t       r_state;
    logic [LEN_W-1:0] r_rem;
    logic             r_sub;

    logic        w_ac;
    logic        w_bc;
    logic [31:0] w_ta;
    logic [31:0] w_tb;
    logic        w_ovf_a;
    logic        w_ovf_b;
    logic [31:0] w_sum;
    logic        w_cout;
    logic        w_c31;
    logic        w_ovf;
    logic [31:0] w_mag;
    sm33_t       w_res;
    logic        w_op_fire;
    logic        w_res_fire;

    assign w_ac = op_a[32];
    assign w_bc = op_b[32] ^ r_sub;

    vpu_sm_to_tc u_conv_a (
        .sign (w_ac),
        .mag  (op_a[31:0]),
        .tc   (w_ta),
        .ovf  (w_ovf_a)
    );

    vpu_sm_to_tc u_conv_b (
        .sign (w_bc),
        .mag  (op_b[31:0]),
        .tc   (w_tb),
        .ovf  (w_ovf_b)
    );

    vpu_ripple_add32 u_add (
        .a    (w_ta),
        .b    (w_tb),
        .cin  (1'b0),
        .sum  (w_sum),
        .cout (w_cout)
    );

    // Carry into the MSB recovered from the MSB sum bit.
    assign w_c31 = w_sum[31] ^ w_ta[31] ^ w_tb[31];
    assign w_ovf = w_ovf_a | w_ovf_b | (w_c31 ^ w_cout);
    assign w_mag = w_sum[31] ? (~w_sum + 32'd1) : w_sum;

`ifdef VPU_ADDSUB_SAT_EN
    logic w_sat_sign;
    assign w_sat_sign = (w_ac == w_bc) ? w_ac : w_sum[31];
    assign w_res      = w_ovf ? {w_sat_sign, SAT_MAG} : {w_sum[31], w_mag};
`else
    assign w_res      = {w_sum[31], w_mag};
`endif

    assign cmd_ready  = (r_state == IDLE);
    assign done       = (r_state == DONE);
    assign op_ready   = (r_state == RUN) && (r_rem != '0) && (!res_valid || res_ready);
    assign w_op_fire  = op_valid && op_ready;
    assign w_res_fire = res_valid && res_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_rem      <= '0;
            r_sub      <= 1'b0;
            res_valid  <= 1'b0;
            res_data   <= '0;
            res_ovf    <= 1'b0;
            ovf_sticky <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cmd_valid) begin
                        r_sub      <= cmd_sub;
                        r_rem      <= cmd_len;
                        ovf_sticky <= 1'b0;
                        r_state    <= (cmd_len == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    // A load may replace a result being accepted this cycle.
                    if (w_op_fire) begin
                        res_data  <= w_res;
                        res_ovf   <= w_ovf;
                        res_valid <= 1'b1;
                        r_rem     <= r_rem - LEN_W'(1);
                        if (w_ovf) begin
                            ovf_sticky <= 1'b1;
                        end
                    end else if (w_res_fire) begin
                        res_valid <= 1'b0;
                    end
                    if ((r_rem == '0) && w_res_fire) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vpu_addsub_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_vpu_addsub_seq
// Description : Directed self-checking bench for vpu_addsub_seq.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vpu_addsub_seq;

    localparam int LEN_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_sub;
    logic [LEN_W-1:0] cmd_len;
    logic             op_valid;
    logic             op_ready;
    logic [32:0]      op_a;
    logic [32:0]      op_b;
    logic             res_valid;
    logic             res_ready;
    logic [32:0]      res_data;
    logic             res_ovf;
    logic             done;
    logic             ovf_sticky;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [32:0] q_data[$];
    logic        q_ovf[$];
    int          last_acc_cyc = 0;
    int          done_cnt     = 0;
    int          stall_seen   = 0;
    int          stall_bad    = 0;
    logic        prev_stall   = 1'b0;
    logic [33:0] prev_out     = '0;

    int          bp_mode = 0;
    logic [3:0]  bp_pat  = 4'b1001;
    logic [1:0]  bp_idx  = 2'd0;

    vpu_addsub_seq #(.LEN_W(LEN_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_sub    (cmd_sub),
        .cmd_len    (cmd_len),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .op_a       (op_a),
        .op_b       (op_b),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_ovf    (res_ovf),
        .done       (done),
        .ovf_sticky (ovf_sticky)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Result collector and stall observer, sampled mid-cycle.
    always @(negedge clk) begin
        if (res_valid && res_ready) begin
            q_data.push_back(res_data);
            q_ovf.push_back(res_ovf);
            last_acc_cyc = cyc;
        end
        if (done) done_cnt++;
        if (prev_stall && res_valid) begin
            stall_seen++;
            if ({res_ovf, res_data} !== prev_out) stall_bad++;
        end
        if (res_valid && !res_ready && op_ready) stall_bad++;
        prev_stall = res_valid && !res_ready && !rst;
        prev_out   = {res_ovf, res_data};
    end

    initial begin
        res_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (bp_mode)
                0: res_ready = 1'b1;
                1: begin
                    res_ready = bp_pat[bp_idx];
                    bp_idx    = bp_idx + 2'd1;
                end
                default: res_ready = 1'b0;
            endcase
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic sub, input logic [LEN_W-1:0] len);
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL cmd_ready_before_cmd: got %b want 1", cmd_ready);
        end
        cmd_valid = 1'b1;
        cmd_sub   = sub;
        cmd_len   = len;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic drive_op(input logic [32:0] a, input logic [32:0] b);
        bit ok = 0;
        op_valid = 1'b1;
        op_a     = a;
        op_b     = b;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (op_ready) begin
                ok = 1;
                break;
            end
        end
        step();
        op_valid = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL op_accept_timeout: got no op_ready within 40 cycles want accept");
        end
    endtask

    task automatic wait_done();
        bit ok = 0;
        for (int k = 0; k < 60; k++) begin
            if (done === 1'b1) begin
                ok = 1;
                break;
            end
            step();
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done within 60 cycles want pulse");
        end
    endtask

    task automatic clear_q();
        q_data.delete();
        q_ovf.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd_valid = 1'b0; cmd_sub = 1'b0; cmd_len = '0;
        op_valid = 1'b0; op_a = '0; op_b = '0;
        repeat (3) step();
        checks++;
        if ({cmd_ready, op_ready, res_valid, res_ovf, done, ovf_sticky} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_flags: got %b want 100000",
                     {cmd_ready, op_ready, res_valid, res_ovf, done, ovf_sticky});
        end
        checks++;
        if (res_data !== 33'h0) begin
            errors++;
            $display("FAIL reset_res_data: got %h want 0", res_data);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_add();
        clear_q();
        send_cmd(1'b0, 8'd1);
        drive_op(33'h0_0000_0005, 33'h0_0000_0003);
        wait_done();
        checks++;
        if (q_data.size() !== 1 || q_data[0] !== 33'h0_0000_0008 || q_ovf[0] !== 1'b0) begin
            errors++;
            $display("FAIL add_result: got n=%0d data=%h ovf=%b want n=1 data=000000008 ovf=0",
                     q_data.size(), q_data[0], q_ovf[0]);
        end
        checks++;
        if (cyc !== last_acc_cyc + 1) begin
            errors++;
            $display("FAIL add_done_latency: got done at cycle %0d want %0d", cyc, last_acc_cyc + 1);
        end
        step();
        checks++;
        if (done !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL add_done_width: got done=%b cmd_ready=%b want done=0 cmd_ready=1",
                     done, cmd_ready);
        end
    endtask

    task automatic test_sub_zero();
        clear_q();
        send_cmd(1'b1, 8'd2);
        drive_op(33'h0_0000_0003, 33'h0_0000_0005);
        drive_op(33'h1_0000_0007, 33'h1_0000_0007);
        wait_done();
        checks++;
        if (q_data.size() !== 2 || q_data[0] !== 33'h1_0000_0002 || q_data[1] !== 33'h0_0000_0000) begin
            errors++;
            $display("FAIL sub_results: got n=%0d %h %h want n=2 100000002 000000000",
                     q_data.size(), q_data[0], q_data[1]);
        end
        checks++;
        if (ovf_sticky !== 1'b0) begin
            errors++;
            $display("FAIL sub_sticky: got %b want 0", ovf_sticky);
        end
        step();
    endtask

    task automatic test_overflow();
        logic [32:0] exp_data;
`ifdef VPU_ADDSUB_SAT_EN
        exp_data = 33'h0_7FFF_FFFF;
`else
        exp_data = 33'h1_8000_0000;
`endif
        clear_q();
        send_cmd(1'b0, 8'd1);
        drive_op(33'h0_7FFF_FFFF, 33'h0_0000_0001);
        wait_done();
        checks++;
        if (q_data.size() !== 1 || q_data[0] !== exp_data || q_ovf[0] !== 1'b1) begin
            errors++;
            $display("FAIL ovf_result: got n=%0d data=%h ovf=%b want n=1 data=%h ovf=1",
                     q_data.size(), q_data[0], q_ovf[0], exp_data);
        end
        checks++;
        if (ovf_sticky !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky: got %b want 1", ovf_sticky);
        end
        step();
    endtask

    task automatic test_back_to_back();
        int d0;
        bp_mode = 1;
        step();
        clear_q();
        stall_seen = 0;
        stall_bad  = 0;
        d0 = done_cnt;
        send_cmd(1'b1, 8'd4);
        checks++;
        if (ovf_sticky !== 1'b0) begin
            errors++;
            $display("FAIL sticky_clear_on_cmd: got %b want 0", ovf_sticky);
        end
        drive_op(33'h0_0000_000A, 33'h1_0000_0001);
        drive_op(33'h0_0000_0064, 33'h0_0000_00C8);
        drive_op(33'h1_0000_0032, 33'h1_0000_0014);
        drive_op(33'h1_0000_0001, 33'h1_0000_0001);
        wait_done();
        step();
        checks++;
        if (q_data.size() !== 4 || q_data[0] !== 33'h0_0000_000B || q_data[1] !== 33'h1_0000_0064
            || q_data[2] !== 33'h1_0000_001E || q_data[3] !== 33'h0_0000_0000) begin
            errors++;
            $display("FAIL bp_results: got n=%0d %h %h %h %h want n=4 00000000b 100000064 10000001e 000000000",
                     q_data.size(), q_data[0], q_data[1], q_data[2], q_data[3]);
        end
        checks++;
        if (stall_seen == 0 || stall_bad != 0) begin
            errors++;
            $display("FAIL bp_stall_hold: got stalls=%0d bad=%0d want stalls>0 bad=0",
                     stall_seen, stall_bad);
        end
        checks++;
        if (done_cnt !== d0 + 1) begin
            errors++;
            $display("FAIL bp_done_count: got %0d want %0d", done_cnt - d0, 1);
        end
        bp_mode = 0;
        step();
    endtask

    task automatic test_zero_len();
        cmd_valid = 1'b1;
        cmd_sub   = 1'b0;
        cmd_len   = '0;
        op_valid  = 1'b1;
        op_a      = 33'h0_0000_0001;
        op_b      = 33'h0_0000_0001;
        step();
        cmd_valid = 1'b0;
        checks++;
        if (done !== 1'b1 || cmd_ready !== 1'b0 || op_ready !== 1'b0) begin
            errors++;
            $display("FAIL zero_len_done: got done=%b cmd_ready=%b op_ready=%b want 1 0 0",
                     done, cmd_ready, op_ready);
        end
        step();
        checks++;
        if (done !== 1'b0 || cmd_ready !== 1'b1 || op_ready !== 1'b0 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL zero_len_idle: got done=%b cmd_ready=%b op_ready=%b res_valid=%b want 0 1 0 0",
                     done, cmd_ready, op_ready, res_valid);
        end
        op_valid = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        bp_mode = 2;
        step();
        send_cmd(1'b0, 8'd3);
        drive_op(33'h0_0000_0001, 33'h0_0000_0001);
        checks++;
        if (res_valid !== 1'b1) begin
            errors++;
            $display("FAIL midrst_pending: got res_valid=%b want 1", res_valid);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (res_valid !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1 || res_data !== 33'h0) begin
            errors++;
            $display("FAIL midrst_state: got res_valid=%b done=%b cmd_ready=%b data=%h want 0 0 1 0",
                     res_valid, done, cmd_ready, res_data);
        end
        bp_mode = 0;
        step();
        clear_q();
        send_cmd(1'b0, 8'd1);
        drive_op(33'h0_0000_0002, 33'h1_0000_0009);
        wait_done();
        checks++;
        if (q_data.size() !== 1 || q_data[0] !== 33'h1_0000_0007 || q_ovf[0] !== 1'b0) begin
            errors++;
            $display("FAIL midrst_fresh: got n=%0d data=%h ovf=%b want n=1 data=100000007 ovf=0",
                     q_data.size(), q_data[0], q_ovf[0]);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_zero();
        test_overflow();
        test_back_to_back();
        test_zero_len();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
